mips_multicycle_control: RTL and testbench

- Multicycle successor to the single-cycle MIPS control unit: one FSM sequences each instruction over 3-5 states, sharing one ALU and one unified memory.
- Adds a memory-ready wait handshake, an optional BNE, illegal-opcode/funct detection and a visible state output.
- Sits between the instruction register and the multicycle datapath: PC, IR, register file, ALU, ALUOut and the memory port.

---
 rtl/mips_multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a single FSM sequences each instruction
// through fetch, decode, execute, memory and write-back. The datapath has
// one ALU and one unified memory. Outputs are decoded combinationally from
// the current state plus the handshake and flag inputs.
module mips_multicycle_control #(
  parameter int ALU_CTRL_W = 3,
  parameter bit ENABLE_BNE = 1'b1,
  parameter bit MEM_WAIT   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            op_code,
  input  logic [5:0]            funct,
  input  logic                  zero_flag,
  input  logic                  mem_ready,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_src,
  output logic                  pc_en,
  output logic                  ir_w,
  output logic                  i_or_d,
  output logic                  mem_r,
  output logic                  mem_w,
  output logic                  reg_w,
  output logic                  reg_dest,
  output logic                  mem_to_reg,
  output logic [3:0]            state,
  output logic                  illegal_op
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       rdy;
  logic       is_beq;
  logic       is_bne;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic [2:0] alu3;

  // Maps an R-type funct field to {legal, ALU code}.
  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    case (f)
      6'b100000: decode_funct = {1'b1, ALU_ADD};
      6'b100010: decode_funct = {1'b1, ALU_SUB};
      6'b100100: decode_funct = {1'b1, ALU_AND};
      6'b100101: decode_funct = {1'b1, ALU_OR};
      6'b101010: decode_funct = {1'b1, ALU_SLT};
      default:   decode_funct = 4'b0000;
    endcase
  endfunction

  // With MEM_WAIT disabled every memory access completes in one cycle.
  assign rdy    = MEM_WAIT ? mem_ready : 1'b1;
  assign is_beq = (op_code == OP_BEQ);
  assign is_bne = ENABLE_BNE && (op_code == OP_BNE);
  assign {funct_ok, funct_alu} = decode_funct(funct);

  assign state       = state_q;
  assign alu_control = ALU_CTRL_W'(alu3);

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Per-state output decode and next-state selection.
  always_comb begin
    state_d    = S_FETCH;
    alu3       = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    ir_w       = 1'b0;
    i_or_d     = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    reg_dest   = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_r     = 1'b1;
        alu_src_b = 2'b01;
        alu3      = ALU_ADD;
        ir_w      = rdy;
        pc_en     = rdy;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm << 2) for a possible branch.
        alu_src_b = 2'b11;
        alu3      = ALU_ADD;
        if (op_code == OP_LW || op_code == OP_SW) state_d = S_MEMADR;
        else if (op_code == OP_RTYPE)             state_d = S_EXECUTE;
        else if (is_beq || is_bne)                state_d = S_BRANCH;
        else if (op_code == OP_ADDI)              state_d = S_ADDIEX;
        else if (op_code == OP_J)                 state_d = S_JUMP;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu3      = ALU_ADD;
        state_d   = (op_code == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_r   = 1'b1;
        i_or_d  = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_w      = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_w   = 1'b1;
        i_or_d  = 1'b1;
        state_d = rdy ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu3      = funct_alu;
        if (funct_ok) state_d = S_ALUWB;
        else          illegal_op = 1'b1;
      end
      S_ALUWB: begin
        // funct is still held in the IR, so re-decoding keeps the code stable.
        alu3     = funct_alu;
        reg_w    = 1'b1;
        reg_dest = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu3      = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = (is_beq & zero_flag) | (is_bne & ~zero_flag);
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu3      = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: reg_w = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Block every architectural write while reset is asserted.
    if (rst) begin
      pc_en      = 1'b0;
      ir_w       = 1'b0;
      mem_r      = 1'b0;
      mem_w      = 1'b0;
      reg_w      = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multicycle MIPS control unit. The stimulus
// process drives one cycle of inputs and queues the expected outputs. The
// monitor pops one entry on each falling edge and compares it.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_nb = 1'b1;
  logic [5:0] op_code = '0;
  logic [5:0] funct = '0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b1;

  logic [2:0] alu_control, nb_alu_control;
  logic       alu_src_a, nb_alu_src_a;
  logic [1:0] alu_src_b, nb_alu_src_b;
  logic [1:0] pc_src, nb_pc_src;
  logic       pc_en, ir_w, i_or_d, mem_r, mem_w, reg_w, reg_dest, mem_to_reg, illegal_op;
  logic       nb_pc_en, nb_ir_w, nb_i_or_d, nb_mem_r, nb_mem_w, nb_reg_w, nb_reg_dest;
  logic       nb_mem_to_reg, nb_illegal_op;
  logic [3:0] state, nb_state;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .op_code(op_code), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_en(pc_en), .ir_w(ir_w), .i_or_d(i_or_d),
    .mem_r(mem_r), .mem_w(mem_w), .reg_w(reg_w), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .state(state), .illegal_op(illegal_op)
  );

  mips_multicycle_control #(.ENABLE_BNE(1'b0)) dut_nb (
    .clk(clk), .rst(rst_nb), .op_code(op_code), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .alu_control(nb_alu_control), .alu_src_a(nb_alu_src_a), .alu_src_b(nb_alu_src_b),
    .pc_src(nb_pc_src), .pc_en(nb_pc_en), .ir_w(nb_ir_w), .i_or_d(nb_i_or_d),
    .mem_r(nb_mem_r), .mem_w(nb_mem_w), .reg_w(nb_reg_w), .reg_dest(nb_reg_dest),
    .mem_to_reg(nb_mem_to_reg), .state(nb_state), .illegal_op(nb_illegal_op)
  );

  // Expected vector layout:
  // {state[3:0], alu[2:0], src_a, src_b[1:0], pc_src[1:0],
  //  pc_en, ir_w, i_or_d, mem_r, mem_w, reg_w, reg_dest, mem_to_reg, illegal_op}
  typedef struct {
    logic        which;
    logic [20:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [20:0] ev(input logic [3:0] st, input logic [2:0] alu,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic [8:0] fl);
    return {st, alu, sa, sb, ps, fl};
  endfunction

  // Hand-written expected outputs for each state visited
  localparam logic [20:0] X_RST    = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 9'b000000000};
  localparam logic [20:0] X_FETCH  = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 9'b110100000};
  localparam logic [20:0] X_FSTALL = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 9'b000100000};
  localparam logic [20:0] X_DEC    = {4'd1,  3'b010, 1'b0, 2'b11, 2'b00, 9'b000000000};
  localparam logic [20:0] X_DECILL = {4'd1,  3'b010, 1'b0, 2'b11, 2'b00, 9'b000000001};
  localparam logic [20:0] X_MADR   = {4'd2,  3'b010, 1'b1, 2'b10, 2'b00, 9'b000000000};
  localparam logic [20:0] X_MRD    = {4'd3,  3'b000, 1'b0, 2'b00, 2'b00, 9'b001100000};
  localparam logic [20:0] X_MWB    = {4'd4,  3'b000, 1'b0, 2'b00, 2'b00, 9'b000001010};
  localparam logic [20:0] X_MWR    = {4'd5,  3'b000, 1'b0, 2'b00, 2'b00, 9'b001010000};
  localparam logic [20:0] X_ADDIEX = {4'd9,  3'b010, 1'b1, 2'b10, 2'b00, 9'b000000000};
  localparam logic [20:0] X_ADDIWB = {4'd10, 3'b000, 1'b0, 2'b00, 2'b00, 9'b000001000};
  localparam logic [20:0] X_JUMP   = {4'd11, 3'b000, 1'b0, 2'b00, 2'b10, 9'b100000000};

  // Drive one cycle of inputs, queue its expectation, advance one clock.
  task automatic step(input logic r, input logic rnb, input logic [5:0] op,
                      input logic [5:0] fn, input logic zf, input logic mr,
                      input logic which, input logic [20:0] e, input string nm);
    exp_t t;
    rst = r; rst_nb = rnb; op_code = op; funct = fn; zero_flag = zf; mem_ready = mr;
    t.which = which; t.exp = e; t.name = nm;
    q.push_back(t);
    @(posedge clk); #1;
  endtask

  // Monitor: compare the selected DUT against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t t;
      logic [20:0] act;
      t = q.pop_front();
      if (t.which)
        act = {nb_state, nb_alu_control, nb_alu_src_a, nb_alu_src_b, nb_pc_src,
               nb_pc_en, nb_ir_w, nb_i_or_d, nb_mem_r, nb_mem_w, nb_reg_w,
               nb_reg_dest, nb_mem_to_reg, nb_illegal_op};
      else
        act = {state, alu_control, alu_src_a, alu_src_b, pc_src,
               pc_en, ir_w, i_or_d, mem_r, mem_w, reg_w, reg_dest, mem_to_reg, illegal_op};
      n_vec++;
      if (act !== t.exp) begin
        n_err++;
        $display("FAIL %s: got state=%0d alu=%b sa=%b sb=%b ps=%b flags=%b, expected state=%0d alu=%b sa=%b sb=%b ps=%b flags=%b",
                 t.name, act[20:17], act[16:14], act[13], act[12:11], act[10:9], act[8:0],
                 t.exp[20:17], t.exp[16:14], t.exp[13], t.exp[12:11], t.exp[10:9], t.exp[8:0]);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    // Reset
    step(1, 1, 6'b000000, 6'b000000, 0, 1, 0, X_RST, "reset_hold");
    // lw, no wait states
    step(0, 1, 6'b100011, 6'b000000, 0, 1, 0, X_FETCH, "lw_fetch");
    step(0, 1, 6'b100011, 6'b000000, 0, 1, 0, X_DEC,   "lw_decode");
    step(0, 1, 6'b100011, 6'b000000, 0, 1, 0, X_MADR,  "lw_memadr");
    step(0, 1, 6'b100011, 6'b000000, 0, 1, 0, X_MRD,   "lw_memrd");
    step(0, 1, 6'b100011, 6'b000000, 0, 1, 0, X_MWB,   "lw_memwb");
    // sw with three wait cycles
    step(0, 1, 6'b101011, 6'b000000, 0, 1, 0, X_FETCH, "sw_fetch");
    step(0, 1, 6'b101011, 6'b000000, 0, 1, 0, X_DEC,   "sw_decode");
    step(0, 1, 6'b101011, 6'b000000, 0, 1, 0, X_MADR,  "sw_memadr");
    for (int i = 0; i < 3; i++)
      step(0, 1, 6'b101011, 6'b000000, 0, 0, 0, X_MWR, "sw_memwr_wait");
    step(0, 1, 6'b101011, 6'b000000, 0, 1, 0, X_MWR,   "sw_memwr_done");
    // R-type slt
    step(0, 1, 6'b000000, 6'b101010, 0, 1, 0, X_FETCH, "slt_fetch");
    step(0, 1, 6'b000000, 6'b101010, 0, 1, 0, X_DEC,   "slt_decode");
    step(0, 1, 6'b000000, 6'b101010, 0, 1, 0, ev(4'd6, 3'b111, 1, 2'b00, 2'b00, 9'b0), "slt_execute");
    step(0, 1, 6'b000000, 6'b101010, 0, 1, 0, ev(4'd7, 3'b111, 0, 2'b00, 2'b00, 9'b000001100), "slt_aluwb");
    // R-type sub
    step(0, 1, 6'b000000, 6'b100010, 0, 1, 0, X_FETCH, "sub_fetch");
    step(0, 1, 6'b000000, 6'b100010, 0, 1, 0, X_DEC,   "sub_decode");
    step(0, 1, 6'b000000, 6'b100010, 0, 1, 0, ev(4'd6, 3'b110, 1, 2'b00, 2'b00, 9'b0), "sub_execute");
    step(0, 1, 6'b000000, 6'b100010, 0, 1, 0, ev(4'd7, 3'b110, 0, 2'b00, 2'b00, 9'b000001100), "sub_aluwb");
    // R-type illegal funct
    step(0, 1, 6'b000000, 6'b000111, 0, 1, 0, X_FETCH, "badfn_fetch");
    step(0, 1, 6'b000000, 6'b000111, 0, 1, 0, X_DEC,   "badfn_decode");
    step(0, 1, 6'b000000, 6'b000111, 0, 1, 0, ev(4'd6, 3'b000, 1, 2'b00, 2'b00, 9'b000000001), "badfn_execute");
    // beq taken / not taken
    step(0, 1, 6'b000100, 6'b000000, 1, 1, 0, X_FETCH, "beq1_fetch");
    step(0, 1, 6'b000100, 6'b000000, 1, 1, 0, X_DEC,   "beq1_decode");
    step(0, 1, 6'b000100, 6'b000000, 1, 1, 0, ev(4'd8, 3'b110, 1, 2'b00, 2'b01, 9'b100000000), "beq_taken");
    step(0, 1, 6'b000100, 6'b000000, 0, 1, 0, X_FETCH, "beq0_fetch");
    step(0, 1, 6'b000100, 6'b000000, 0, 1, 0, X_DEC,   "beq0_decode");
    step(0, 1, 6'b000100, 6'b000000, 0, 1, 0, ev(4'd8, 3'b110, 1, 2'b00, 2'b01, 9'b000000000), "beq_not_taken");
    // bne with zero=1 (not taken) and zero=0 (taken)
    step(0, 1, 6'b000101, 6'b000000, 1, 1, 0, X_FETCH, "bne1_fetch");
    step(0, 1, 6'b000101, 6'b000000, 1, 1, 0, X_DEC,   "bne1_decode");
    step(0, 1, 6'b000101, 6'b000000, 1, 1, 0, ev(4'd8, 3'b110, 1, 2'b00, 2'b01, 9'b000000000), "bne_not_taken");
    step(0, 1, 6'b000101, 6'b000000, 0, 1, 0, X_FETCH, "bne0_fetch");
    step(0, 1, 6'b000101, 6'b000000, 0, 1, 0, X_DEC,   "bne0_decode");
    step(0, 1, 6'b000101, 6'b000000, 0, 1, 0, ev(4'd8, 3'b110, 1, 2'b00, 2'b01, 9'b100000000), "bne_taken");
    // addi
    step(0, 1, 6'b001000, 6'b000000, 0, 1, 0, X_FETCH,  "addi_fetch");
    step(0, 1, 6'b001000, 6'b000000, 0, 1, 0, X_DEC,    "addi_decode");
    step(0, 1, 6'b001000, 6'b000000, 0, 1, 0, X_ADDIEX, "addi_ex");
    step(0, 1, 6'b001000, 6'b000000, 0, 1, 0, X_ADDIWB, "addi_wb");
    // j
    step(0, 1, 6'b000010, 6'b000000, 0, 1, 0, X_FETCH, "j_fetch");
    step(0, 1, 6'b000010, 6'b000000, 0, 1, 0, X_DEC,   "j_decode");
    step(0, 1, 6'b000010, 6'b000000, 0, 1, 0, X_JUMP,  "j_jump");
    // Unknown opcode, then FETCH stalled on mem_ready
    step(0, 1, 6'b111111, 6'b000000, 0, 1, 0, X_FETCH,  "badop_fetch");
    step(0, 1, 6'b111111, 6'b000000, 0, 1, 0, X_DECILL, "badop_decode");
    step(0, 1, 6'b111111, 6'b000000, 0, 0, 0, X_FSTALL, "fetch_stall1");
    step(0, 1, 6'b111111, 6'b000000, 0, 0, 0, X_FSTALL, "fetch_stall2");
    step(0, 1, 6'b100011, 6'b000000, 0, 1, 0, X_FETCH,  "fetch_resume");
    // Reset asserted mid-MEMRD
    step(0, 1, 6'b100011, 6'b000000, 0, 1, 0, X_DEC,   "rlw_decode");
    step(0, 1, 6'b100011, 6'b000000, 0, 1, 0, X_MADR,  "rlw_memadr");
    step(0, 1, 6'b100011, 6'b000000, 0, 0, 0, X_MRD,   "rlw_memrd_wait");
    step(1, 1, 6'b100011, 6'b000000, 0, 1, 0, X_RST,   "async_reset");
    step(0, 1, 6'b100011, 6'b000000, 0, 1, 0, X_FETCH, "post_reset_fetch");
    // ENABLE_BNE=0 instance: bne is illegal in DECODE
    step(1, 0, 6'b000101, 6'b000000, 0, 1, 1, X_FETCH,  "nobne_fetch");
    step(1, 0, 6'b000101, 6'b000000, 0, 1, 1, X_DECILL, "nobne_decode");
    step(1, 0, 6'b000101, 6'b000000, 0, 1, 1, X_FETCH,  "nobne_back_to_fetch");

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
